open_list_queue: RTL and testbench
==================================

// Module: open_list_queue
// PURPOSE
//  A* open set for the search engine: sorted priority queue of {f_cost, node_id}.
//  Sits directly upstream of search: neighbour inserts come in, and search pops the
//  lowest-f node each expansion step.
//  Merges duplicate nodes on insert: keeps the lower f, drops the worse one.
//  Single clock domain. Clk only.
// PARAMETERS
//  DEPTH   16  entry count; power of 2 not required, >=2
//  NODE_W  8   node id width (grid cell index)
//  COST_W  10  f-cost width, unsigned
// PORTS
//  Clk        in   1                    system clock, rising edge
//  Reset      in   1                    synchronous, active-high; empties queue, FSM->IDLE
//  clear      in   1                    synchronous flush; same effect as Reset, any state
//  ins_valid  in   1                    insert request
//  ins_ready  out  1                    high only in IDLE
//  ins_node   in   NODE_W               node to insert
//  ins_f      in   COST_W               f-cost of node
//  pop_valid  out  1                    head valid: !empty && state==IDLE
//  pop_req    in   1                    consume head; ignored unless pop_valid
//  pop_node   out  NODE_W               head node (entry 0), combinational from regs
//  pop_f      out  COST_W               head f-cost
//  count      out  $clog2(DEPTH+1)      valid entries
//  empty      out  1                    count==0
//  full       out  1                    count==DEPTH
//  dup_drop   out  1                    1-cycle pulse: insert discarded as worse duplicate
//  overflow   out  1                    sticky: insert arrived while full; cleared by Reset/clear
// BEHAVIOUR
//  Reset/clear: count=0, all valid bits 0, state=IDLE, ins_ready=1, pop_valid=0,
//   dup_drop=0, overflow=0, pop_node/pop_f=0.
//  Order: entries 0..count-1 ascending f; equal f -> older entry first (stable).
//  FSM IDLE -> SCAN -> WRITE -> IDLE.
//   IDLE:  accept when ins_valid&&ins_ready; latch node/f; go to SCAN.
//   SCAN:  compare against all valid slots in parallel; register match_hit/match_idx
//          and ins_pos (first slot with f > ins_f, else count).
//   WRITE: apply one of:
//          - match and ins_f>=old f: drop, pulse dup_drop.
//          - match and ins_f<old f: remove old slot, insert at ins_pos (count unchanged).
//          - no match, !full: shift slots >=ins_pos up one, write, count+1.
//          - no match, full: set overflow. If ins_f < tail f, evict tail and insert;
//            otherwise drop.
//  Insert latency: accepted at edge T, visible at head by edge T+3; ins_ready is low
//   for T+1 and T+2. Max throughput is 1 insert per 3 cycles.
//  Pop: in IDLE with pop_valid&&pop_req, slots shift down one and count-1 at the next
//   edge. pop_req while empty or not IDLE has no effect.
//  Simultaneous insert accept + pop in IDLE: the pop executes that edge, and SCAN
//   runs on the shifted array. A popped node matching ins_node is therefore not a
//   duplicate.
//  clear has priority over every other action in any state; an in-flight insert is
//   lost. Reset mid-operation behaves the same.
//  Widths: no cost arithmetic inside; compares are unsigned COST_W. count never
//   exceeds DEPTH and never underflows.
// STRUCTURE
//  astar_pkg: NODE_W, COST_W constants; typedef ol_entry_t {f[COST_W], node[NODE_W]};
//   shared with search and the neighbour expander.
//  Sub-module open_list_cell (DEPTH instances) holds:
//   - valid + entry register
//   - node==key compare and f>key compare outputs
//   - shift-up/shift-down/load mux controlled by the top FSM.
//  Top level holds FSM, priority encoders for match_idx/ins_pos, and the counters.
// TESTING
//  1 Reset, insert (5,f40),(7,f20),(9,f30) -> pops in order 7/20, 9/30, 5/40;
//    empty=1 after the third pop.
//  2 Insert (3,f25) then (4,f25) -> head 3 first (stable ties). count=2.
//  3 Insert (6,f50) then (6,f35) -> count=1, head 6/35.
//    Then insert (6,f60) -> dup_drop pulses, head still 6/35.
//  4 Fill DEPTH=16 with f=10..160 step 10. Insert (99,f5) -> overflow=1, tail f160
//    evicted, head 99/5. Then insert (98,f500) -> dropped, count=16.
//  5 Insert accepted at T with pop_req same cycle -> ins_ready low T+1..T+2, pop_valid
//    low during SCAN/WRITE, new entry visible T+3.
//  6 Assert clear during WRITE with count=4 -> next cycle count=0, empty=1,
//    overflow=0, ins_ready=1.

Source files
------------

// File: rtl/open_list_queue_pkg.sv
// Shared A* open-list types: default widths, entry layout, FSM and cell-op encodings.
package open_list_queue_pkg;

  localparam int OL_DEPTH  = 16;
  localparam int OL_NODE_W = 8;
  localparam int OL_COST_W = 10;

  typedef struct packed {
    logic [OL_COST_W-1:0] f;
    logic [OL_NODE_W-1:0] node;
  } ol_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } ol_state_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } cell_op_t;

endpackage

// File: rtl/open_list_queue_if.sv
// Insert/pop handshake between the open list and its neighbour expander / search engine.
interface open_list_queue_if #(
  parameter int NODE_W = 8,
  parameter int COST_W = 10
);
  logic              ins_valid;
  logic              ins_ready;
  logic [NODE_W-1:0] ins_node;
  logic [COST_W-1:0] ins_f;
  logic              pop_valid;
  logic              pop_req;
  logic [NODE_W-1:0] pop_node;
  logic [COST_W-1:0] pop_f;

  modport master (
    output ins_valid, ins_node, ins_f, pop_req,
    input  ins_ready, pop_valid, pop_node, pop_f
  );

  modport slave (
    input  ins_valid, ins_node, ins_f, pop_req,
    output ins_ready, pop_valid, pop_node, pop_f
  );
endinterface

// File: rtl/open_list_queue_cell.sv
// One open-list slot: valid + {f,node} register, key compares, and the shift/load mux.
module open_list_queue_cell
  import open_list_queue_pkg::*;
#(
  parameter int NODE_W = OL_NODE_W,
  parameter int COST_W = OL_COST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  cell_op_t          op,
  input  logic              up_valid,
  input  logic [NODE_W-1:0] up_node,
  input  logic [COST_W-1:0] up_f,
  input  logic              dn_valid,
  input  logic [NODE_W-1:0] dn_node,
  input  logic [COST_W-1:0] dn_f,
  input  logic [NODE_W-1:0] key_node,
  input  logic [COST_W-1:0] key_f,
  output logic              valid,
  output logic [NODE_W-1:0] node,
  output logic [COST_W-1:0] f,
  output logic              node_eq,
  output logic              f_gt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      node  <= '0;
      f     <= '0;
    end else begin
      case (op)
        OP_LOAD: begin
          valid <= 1'b1;
          node  <= key_node;
          f     <= key_f;
        end
        OP_UP: begin
          valid <= up_valid;
          node  <= up_node;
          f     <= up_f;
        end
        OP_DOWN: begin
          valid <= dn_valid;
          node  <= dn_node;
          f     <= dn_f;
        end
        default: ;
      endcase
    end
  end

  assign node_eq = valid && (node == key_node);
  assign f_gt    = valid && (f > key_f);

endmodule

// File: rtl/open_list_queue.sv
// A* open set: sorted {f,node} priority queue with duplicate merge on insert.
module open_list_queue
  import open_list_queue_pkg::*;
#(
  parameter int DEPTH  = OL_DEPTH,
  parameter int NODE_W = OL_NODE_W,
  parameter int COST_W = OL_COST_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       clear,
  open_list_queue_if.slave           q,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       dup_drop,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH+1);

  logic              flush;
  ol_state_t         state_q, state_d;
  logic [NODE_W-1:0] key_node;
  logic [COST_W-1:0] key_f;
  logic              match_hit;
  logic [CW-1:0]     match_idx, ins_pos, count_q;

  // Slot k lives at index k+1; indices 0 and DEPTH+1 are permanent empty neighbours.
  logic [DEPTH+1:0]             v_ext;
  logic [DEPTH+1:0][NODE_W-1:0] n_ext;
  logic [DEPTH+1:0][COST_W-1:0] f_ext;
  logic [DEPTH-1:0]             node_eq, f_gt;
  cell_op_t                     cell_op [DEPTH];

  logic              accept, pop_fire, do_ins, grow, drop_dup, set_ovf;
  logic [CW-1:0]     hi;
  logic              scan_hit, pos_found;
  logic [CW-1:0]     scan_idx, scan_pos;
  logic [COST_W-1:0] old_f;

  assign flush    = Reset | clear;
  assign v_ext[0] = 1'b0;
  assign n_ext[0] = '0;
  assign f_ext[0] = '0;
  assign v_ext[DEPTH+1] = 1'b0;
  assign n_ext[DEPTH+1] = '0;
  assign f_ext[DEPTH+1] = '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    open_list_queue_cell #(
      .NODE_W (NODE_W),
      .COST_W (COST_W)
    ) u_cell (
      .clk      (Clk),
      .rst      (flush),
      .op       (cell_op[g]),
      .up_valid (v_ext[g]),
      .up_node  (n_ext[g]),
      .up_f     (f_ext[g]),
      .dn_valid (v_ext[g+2]),
      .dn_node  (n_ext[g+2]),
      .dn_f     (f_ext[g+2]),
      .key_node (key_node),
      .key_f    (key_f),
      .valid    (v_ext[g+1]),
      .node     (n_ext[g+1]),
      .f        (f_ext[g+1]),
      .node_eq  (node_eq[g]),
      .f_gt     (f_gt[g])
    );
  end

  always_ff @(posedge Clk) begin
    if (flush) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SCAN;
      ST_SCAN:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    old_f = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (CW'(i) == match_idx) old_f = f_ext[i+1];
  end

  always_comb begin
    q.ins_ready = (state_q == ST_IDLE);
    q.pop_valid = (state_q == ST_IDLE) && (count_q != '0);
    accept      = q.ins_valid && q.ins_ready;
    pop_fire    = q.pop_valid && q.pop_req;
    do_ins      = 1'b0;
    grow        = 1'b0;
    drop_dup    = 1'b0;
    set_ovf     = 1'b0;
    hi          = '0;
    if (state_q == ST_WRITE) begin
      if (match_hit) begin
        // ins_pos <= match_idx here, so the shift window closes over the stale copy.
        if (key_f >= old_f) drop_dup = 1'b1;
        else begin
          do_ins = 1'b1;
          hi     = match_idx;
        end
      end else if (!full) begin
        do_ins = 1'b1;
        grow   = 1'b1;
        hi     = count_q;
      end else begin
        set_ovf = 1'b1;
        if (key_f < f_ext[DEPTH]) begin
          do_ins = 1'b1;
          hi     = CW'(DEPTH-1);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cell_op[i] = OP_HOLD;
      if (pop_fire) cell_op[i] = OP_DOWN;
      else if (do_ins) begin
        if (CW'(i) == ins_pos)                     cell_op[i] = OP_LOAD;
        else if (CW'(i) > ins_pos && CW'(i) <= hi) cell_op[i] = OP_UP;
      end
    end
  end

  // Valid slots are contiguous and sorted, so the first f > key is the stable insert point.
  always_comb begin
    scan_hit  = 1'b0;
    scan_idx  = '0;
    pos_found = 1'b0;
    scan_pos  = count_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (node_eq[i] && !scan_hit) begin
        scan_hit = 1'b1;
        scan_idx = CW'(i);
      end
      if (f_gt[i] && !pos_found) begin
        pos_found = 1'b1;
        scan_pos  = CW'(i);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (flush) begin
      count_q   <= '0;
      key_node  <= '0;
      key_f     <= '0;
      match_hit <= 1'b0;
      match_idx <= '0;
      ins_pos   <= '0;
      dup_drop  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      dup_drop <= drop_dup;
      if (set_ovf) overflow <= 1'b1;
      if (accept) begin
        key_node <= q.ins_node;
        key_f    <= q.ins_f;
      end
      if (state_q == ST_SCAN) begin
        match_hit <= scan_hit;
        match_idx <= scan_idx;
        ins_pos   <= scan_pos;
      end
      if (pop_fire)  count_q <= count_q - CW'(1);
      else if (grow) count_q <= count_q + CW'(1);
    end
  end

  assign q.pop_node = n_ext[1];
  assign q.pop_f    = f_ext[1];
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_open_list_queue.sv
// Directed bench for open_list_queue: ordering, ties, merge, overflow, pop overlap, clear.
module tb_open_list_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [4:0] count;
  logic       empty, full, dup_drop, overflow;
  int         checks = 0;
  int         errors = 0;

  open_list_queue_if #(.NODE_W(8), .COST_W(10)) qif ();

  open_list_queue #(
    .DEPTH  (16),
    .NODE_W (8),
    .COST_W (10)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .clear    (clear),
    .q        (qif),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .dup_drop (dup_drop),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Drive at a negedge; returns at the negedge right after the WRITE edge.
  task automatic do_insert(input logic [7:0] n, input logic [9:0] f, output logic dd);
    int unsigned k = 0;
    while (!qif.ins_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!qif.ins_ready) begin
      checks++;
      errors++;
      $display("FAIL ins_ready_timeout got=%0b want=1", qif.ins_ready);
    end
    qif.ins_valid = 1'b1;
    qif.ins_node  = n;
    qif.ins_f     = f;
    @(negedge clk);
    qif.ins_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dd = dup_drop;
  endtask

  task automatic do_pop();
    qif.pop_req = 1'b1;
    @(negedge clk);
    qif.pop_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (count !== 5'd0)       begin errors++; $display("FAIL rst_count got=%0d want=0", count); end
    checks++; if (empty !== 1'b1)       begin errors++; $display("FAIL rst_empty got=%0b want=1", empty); end
    checks++; if (full !== 1'b0)        begin errors++; $display("FAIL rst_full got=%0b want=0", full); end
    checks++; if (qif.ins_ready !== 1'b1) begin errors++; $display("FAIL rst_ins_ready got=%0b want=1", qif.ins_ready); end
    checks++; if (qif.pop_valid !== 1'b0) begin errors++; $display("FAIL rst_pop_valid got=%0b want=0", qif.pop_valid); end
    checks++; if (dup_drop !== 1'b0)    begin errors++; $display("FAIL rst_dup_drop got=%0b want=0", dup_drop); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_overflow got=%0b want=0", overflow); end
    checks++; if (qif.pop_node !== 8'd0 || qif.pop_f !== 10'd0) begin
      errors++; $display("FAIL rst_head got=%0d/%0d want=0/0", qif.pop_node, qif.pop_f);
    end
  endtask

  task automatic test_order();
    logic dd;
    logic [7:0] exp_n [3] = '{8'd7, 8'd9, 8'd5};
    logic [9:0] exp_f [3] = '{10'd20, 10'd30, 10'd40};
    do_insert(8'd5, 10'd40, dd);
    do_insert(8'd7, 10'd20, dd);
    do_insert(8'd9, 10'd30, dd);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL order_count got=%0d want=3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (qif.pop_valid !== 1'b1 || qif.pop_node !== exp_n[i] || qif.pop_f !== exp_f[i]) begin
        errors++;
        $display("FAIL order_head%0d got=%0b:%0d/%0d want=1:%0d/%0d", i, qif.pop_valid,
                 qif.pop_node, qif.pop_f, exp_n[i], exp_f[i]);
      end
      do_pop();
    end
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL order_empty got=%0b/%0d want=1/0", empty, count);
    end
  endtask

  task automatic test_stable_ties();
    logic dd;
    do_insert(8'd3, 10'd25, dd);
    do_insert(8'd4, 10'd25, dd);
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL tie_count got=%0d want=2", count); end
    checks++; if (qif.pop_node !== 8'd3 || qif.pop_f !== 10'd25) begin
      errors++; $display("FAIL tie_head got=%0d/%0d want=3/25", qif.pop_node, qif.pop_f);
    end
    do_pop();
    checks++; if (qif.pop_node !== 8'd4 || qif.pop_f !== 10'd25) begin
      errors++; $display("FAIL tie_second got=%0d/%0d want=4/25", qif.pop_node, qif.pop_f);
    end
    do_pop();
  endtask

  task automatic test_dup_merge();
    logic dd;
    do_insert(8'd6, 10'd50, dd);
    do_insert(8'd6, 10'd35, dd);
    checks++; if (dd !== 1'b0) begin errors++; $display("FAIL dup_better_drop got=%0b want=0", dd); end
    checks++; if (count !== 5'd1 || qif.pop_node !== 8'd6 || qif.pop_f !== 10'd35) begin
      errors++; $display("FAIL dup_better got=%0d:%0d/%0d want=1:6/35", count, qif.pop_node, qif.pop_f);
    end
    do_insert(8'd6, 10'd60, dd);
    checks++; if (dd !== 1'b1) begin errors++; $display("FAIL dup_worse_pulse got=%0b want=1", dd); end
    @(negedge clk);
    checks++; if (dup_drop !== 1'b0) begin errors++; $display("FAIL dup_pulse_len got=%0b want=0", dup_drop); end
    checks++; if (count !== 5'd1 || qif.pop_node !== 8'd6 || qif.pop_f !== 10'd35) begin
      errors++; $display("FAIL dup_worse got=%0d:%0d/%0d want=1:6/35", count, qif.pop_node, qif.pop_f);
    end
    do_pop();
  endtask

  task automatic test_overflow();
    logic dd;
    for (int i = 1; i <= 16; i++) do_insert(8'(i), 10'(10 * i), dd);
    checks++; if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      errors++; $display("FAIL fill got=%0b/%0d/%0b want=1/16/0", full, count, overflow);
    end
    do_insert(8'd99, 10'd5, dd);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b want=1", overflow); end
    checks++; if (count !== 5'd16 || qif.pop_node !== 8'd99 || qif.pop_f !== 10'd5) begin
      errors++; $display("FAIL ovf_head got=%0d:%0d/%0d want=16:99/5", count, qif.pop_node, qif.pop_f);
    end
    do_insert(8'd98, 10'd500, dd);
    checks++; if (count !== 5'd16 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drop got=%0d/%0b want=16/1", count, overflow);
    end
    do_pop();
    for (int i = 1; i <= 15; i++) begin
      checks++;
      if (qif.pop_node !== 8'(i) || qif.pop_f !== 10'(10 * i)) begin
        errors++;
        $display("FAIL ovf_drain%0d got=%0d/%0d want=%0d/%0d", i, qif.pop_node, qif.pop_f, i, 10 * i);
      end
      do_pop();
    end
    checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got=%0b/%0b want=1/1", empty, overflow);
    end
  endtask

  task automatic test_clear_mid_write();
    logic dd;
    for (int i = 0; i < 4; i++) do_insert(8'(10 + i), 10'(100 + 10 * i), dd);
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL clr_pre_count got=%0d want=4", count); end
    qif.ins_valid = 1'b1;
    qif.ins_node  = 8'd14;
    qif.ins_f     = 10'd1;
    @(negedge clk);
    qif.ins_valid = 1'b0;
    @(negedge clk);
    checks++; if (qif.ins_ready !== 1'b0) begin errors++; $display("FAIL clr_in_write got=%0b want=0", qif.ins_ready); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL clr_count got=%0d/%0b want=0/1", count, empty);
    end
    checks++; if (overflow !== 1'b0 || qif.ins_ready !== 1'b1 || qif.pop_valid !== 1'b0) begin
      errors++; $display("FAIL clr_flags got=%0b/%0b/%0b want=0/1/0", overflow, qif.ins_ready, qif.pop_valid);
    end
    checks++; if (qif.pop_node !== 8'd0 || qif.pop_f !== 10'd0) begin
      errors++; $display("FAIL clr_head got=%0d/%0d want=0/0", qif.pop_node, qif.pop_f);
    end
  endtask

  task automatic test_back_to_back();
    logic dd;
    logic [7:0] new_n [2] = '{8'd2, 8'd2};
    logic [9:0] new_f [2] = '{10'd50, 10'd70};
    do_insert(8'd1, 10'd30, dd);
    for (int r = 0; r < 2; r++) begin
      qif.ins_valid = 1'b1;
      qif.ins_node  = new_n[r];
      qif.ins_f     = new_f[r];
      qif.pop_req   = 1'b1;
      @(negedge clk);
      qif.ins_valid = 1'b0;
      checks++; if (qif.ins_ready !== 1'b0 || qif.pop_valid !== 1'b0 || count !== 5'd0) begin
        errors++; $display("FAIL b2b_scan%0d got=%0b/%0b/%0d want=0/0/0", r, qif.ins_ready, qif.pop_valid, count);
      end
      @(negedge clk);
      checks++; if (qif.ins_ready !== 1'b0 || qif.pop_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_write%0d got=%0b/%0b want=0/0", r, qif.ins_ready, qif.pop_valid);
      end
      qif.pop_req = 1'b0;
      @(negedge clk);
      checks++;
      if (qif.ins_ready !== 1'b1 || qif.pop_valid !== 1'b1 || count !== 5'd1 ||
          qif.pop_node !== new_n[r] || qif.pop_f !== new_f[r] || dup_drop !== 1'b0) begin
        errors++;
        $display("FAIL b2b_visible%0d got=%0b/%0b/%0d/%0d/%0d/%0b want=1/1/1/%0d/%0d/0", r,
                 qif.ins_ready, qif.pop_valid, count, qif.pop_node, qif.pop_f, dup_drop, new_n[r], new_f[r]);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    qif.ins_valid = 1'b0;
    qif.ins_node  = '0;
    qif.ins_f     = '0;
    qif.pop_req   = 1'b0;
    test_reset();
    test_order();
    test_stable_ties();
    test_dup_merge();
    test_overflow();
    test_clear_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
